gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer for a 2-input combinational gate-under-test (inputs x, y; output z) in the lab project. On a start request it drives all four input combinations in order, holds each for a programmable settle time, and samples z once per vector. At the end it compares the observed truth table against an expected one and reports a per-vector fail mask, an error count and pass/fail. It replaces hand-written stimulus sequences with one reusable, self-checking controller that can sit in a fixture or on the board.

## Interface
- SETTLE, 2: cycles each vector is held before z is sampled; legal range 1..15.
- EXPECT, 4'b1000: expected z per vector index i = {x,y}. Bit i holds the expected z. The default is AND.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel the current sweep; synchronous.
- z  in  1  gate-under-test output.
- x  out  1  gate input, equal to vector index bit 1.
- y  out  1  gate input, equal to vector index bit 0.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse when results are valid.
- pass  out  1  high when err_cnt == 0; valid from the done pulse onward.
- err_cnt  out  3  number of mismatching vectors, 0..4.
- fail_vec  out  4  bit i is high if vector i mismatched.
- obs_vec  out  4  bit i is z as sampled for vector i.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE. A 2-bit index idx and a 4-bit settle counter cnt track progress.
- IDLE
  - x = y = 0 and busy = 0.
  - When start = 1: idx <= 0, cnt <= SETTLE-1, obs_vec <= 0, then go to SETTLE.
- SETTLE
  - {x,y} = idx and busy = 1.
  - Decrement cnt. When cnt == 0, go to SAMPLE.
- SAMPLE
  - {x,y} = idx and busy = 1.
  - At the end of the cycle, obs_vec[idx] <= z.
  - If idx == 3, go to DONE. Otherwise idx <= idx+1, cnt <= SETTLE-1, and go to SETTLE.
- DONE
  - Lasts one cycle: done = 1, busy = 0, x = y = 0.
  - fail_vec, err_cnt and pass were registered on entry, computed as fail_vec = obs_vec ^ EXPECT and err_cnt = popcount(fail_vec). The popcount includes the vector-3 sample taken on the same edge.
  - Next state is IDLE.
- Results (pass, err_cnt, fail_vec, obs_vec) hold their values in IDLE until the next accepted start.
  - On the start edge, obs_vec clears; fail_vec, err_cnt and pass clear at the same time.
- A start that arrives while not in IDLE is ignored and is not queued.
- Abort has priority over start and over every state transition.
  - From any state it forces IDLE and clears obs_vec, fail_vec, err_cnt and pass to 0.
  - done is not pulsed.
  - Abort while in IDLE only clears the results.
- Reset has priority over abort. Reset mid-sweep behaves like abort.
- z is treated as a 2-state value; unknown values are not detected.

## Timing
- Reset values: x = 0, y = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, fail_vec = 0, obs_vec = 0, state = IDLE.
- Let edge k be the edge that samples start = 1 in IDLE.
  - Vector i is driven during cycles k+1+i(SETTLE+1) through k+(i+1)(SETTLE+1).
  - z is sampled in the last of those cycles.
- busy is high for 4(SETTLE+1) cycles.
- done is high for exactly one cycle, at cycle k+1+4(SETTLE+1).
- The earliest next start is accepted in the cycle after done, which is IDLE.
- x and y change only at vector boundaries, so the gate sees at least SETTLE+1 stable cycles per vector.
- All outputs are registered.

## Test plan
- **Correct AND gate, EXPECT = 4'b1000, SETTLE = 2.**
  - Stimulus: pulse start.
  - Required response:
    - x,y read 00, 01, 10, 11, each for 3 cycles.
    - busy is high for 12 cycles.
    - done pulses at start-edge + 13.
    - obs_vec = 4'b1000, fail_vec = 0, err_cnt = 0, pass = 1.
- **Wrong gate, OR in place of AND.**
  - Stimulus: same sweep as above.
  - Required response: obs_vec = 4'b1110, fail_vec = 4'b0110, err_cnt = 2, pass = 0.
- **Inverted gate, NAND.**
  - Stimulus: same sweep as above.
  - Required response: fail_vec = 4'b1111, err_cnt = 4.
- **Start and abort handling.**
  - Stimulus:
    - Pulse start again during the second vector.
    - Later assert abort during the third vector.
  - Required response:
    - The second start has no effect.
    - One cycle after abort: IDLE, x = y = 0, busy = 0, all results 0.
    - done never pulses.
- **Reset mid-sweep.**
  - Stimulus: drive rst_n = 0 for one cycle during vector 1.
  - Required response: every output equals its reset value. A subsequent start runs a full sweep normally.
- **SETTLE = 1 with back-to-back starts.**
  - Stimulus: assert start in the cycle right after done.
  - Required response:
    - Each vector is held 2 cycles and done lands at +9.
    - The second sweep begins immediately.
    - The results of the first sweep stay valid until that second start edge.

Source files
------------

// File: rtl/gate_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and whatever drives start/abort
// and closes the loop through the gate-under-test output z.
interface gate_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       z;
  logic       x;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [3:0] obs_vec;

  modport master (
    output start, abort, z,
    input  x, y, busy, done, pass, err_cnt, fail_vec, obs_vec
  );

  modport slave (
    input  start, abort, z,
    output x, y, busy, done, pass, err_cnt, fail_vec, obs_vec
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep of a 2-input gate: applies {x,y} = 0..3, holds each for
// SETTLE cycles, samples z, and reports the mismatch mask against EXPECT.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = 4'b1000
) (
  input logic              clk,
  input logic              rst_n,
  gate_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] obs_q, obs_d;
  logic [3:0] fail_q, fail_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       x_q, x_d;
  logic       y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    obs_d   = obs_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          cnt_d   = CNT_RELOAD;
          obs_d   = '0;
          fail_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        obs_d[idx_q] = bus.z;
        if (idx_q == 2'd3) begin
          // Results use obs_d so the final vector's sample is included.
          fail_d = obs_d ^ EXPECT;
          err_d  = '0;
          for (int unsigned i = 0; i < 4; i++) begin
            err_d = err_d + {2'b00, fail_d[i]};
          end
          pass_d  = (fail_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_RELOAD;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      obs_d   = '0;
      fail_d  = '0;
      err_d   = '0;
      pass_d  = 1'b0;
    end

    // Outputs are decoded from the next state so they can be registered.
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    x_d    = busy_d & idx_d[1];
    y_d    = busy_d & idx_d[0];
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      obs_q   <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      obs_q   <= obs_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;
  assign bus.obs_vec  = obs_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1) checked every
// cycle against a time-since-start model, plus directed literal expectations.
module tb_gate_sweep_ctrl;

  localparam int         S0 = 2;
  localparam int         S1 = 1;
  localparam logic [3:0] E0 = 4'b1000;
  localparam logic [3:0] E1 = 4'b0110;

  localparam logic [3:0] G_AND  = 4'b1000;
  localparam logic [3:0] G_OR   = 4'b1110;
  localparam logic [3:0] G_NAND = 4'b0111;
  localparam logic [3:0] G_XOR  = 4'b0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st[2];
  logic       ab[2];
  logic [3:0] tbl[2];
  logic [15:0] dout[2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  gate_sweep_ctrl_if if0();
  gate_sweep_ctrl_if if1();

  assign if0.start = st[0];
  assign if0.abort = ab[0];
  assign if0.z     = tbl[0][{if0.x, if0.y}];
  assign if1.start = st[1];
  assign if1.abort = ab[1];
  assign if1.z     = tbl[1][{if1.x, if1.y}];

  // {x, y, busy, done, pass, err_cnt[2:0], fail_vec[3:0], obs_vec[3:0]}
  assign dout[0] = {if0.x, if0.y, if0.busy, if0.done, if0.pass,
                    if0.err_cnt, if0.fail_vec, if0.obs_vec};
  assign dout[1] = {if1.x, if1.y, if1.busy, if1.done, if1.pass,
                    if1.err_cnt, if1.fail_vec, if1.obs_vec};

  gate_sweep_ctrl #(.SETTLE(S0), .EXPECT(E0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  gate_sweep_ctrl #(.SETTLE(S1), .EXPECT(E1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_t counts cycles since the accepted start edge (1 = first vector cycle).
  bit         m_act[2];
  int         m_t[2];
  logic [3:0] m_obs[2];
  logic [3:0] m_fail[2];
  int         m_err[2];
  bit         m_pass[2];

  function automatic int sett(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic logic [3:0] expv(input int i);
    return (i == 0) ? E0 : E1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_obs[i] = '0; m_fail[i] = '0; m_err[i] = 0; m_pass[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int per;
      int len;
      per = sett(i) + 1;
      len = 4 * per;
      if (!rst_n || ab[i]) begin
        m_act[i] = 0; m_obs[i] = '0; m_fail[i] = '0; m_err[i] = 0; m_pass[i] = 0;
      end else if (m_act[i]) begin
        if (m_t[i] <= len && (m_t[i] % per) == 0)
          m_obs[i][m_t[i] / per - 1] = tbl[i][m_t[i] / per - 1];
        if (m_t[i] == len) begin
          m_fail[i] = m_obs[i] ^ expv(i);
          m_err[i]  = $countones(m_fail[i]);
          m_pass[i] = (m_err[i] == 0);
        end
        if (m_t[i] == len + 1) m_act[i] = 0;
        else m_t[i] = m_t[i] + 1;
      end else if (st[i]) begin
        m_act[i] = 1; m_t[i] = 1;
        m_obs[i] = '0; m_fail[i] = '0; m_err[i] = 0; m_pass[i] = 0;
      end
    end
  end

  function automatic logic [15:0] mexp(input int i);
    int per;
    int len;
    int v;
    logic [1:0] vb;
    bit sw;
    per = sett(i) + 1;
    len = 4 * per;
    sw  = m_act[i] && (m_t[i] <= len);
    v   = (m_t[i] - 1) / per;
    vb  = 2'(v);
    return {sw & vb[1], sw & vb[0], sw, (m_act[i] && m_t[i] == len + 1), m_pass[i],
            3'(m_err[i]), m_fail[i], m_obs[i]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] e;
        logic [15:0] a;
        e = mexp(i);
        a = dout[i];
        chk($sformatf("i%0d.x", i),        a[15],    e[15]);
        chk($sformatf("i%0d.y", i),        a[14],    e[14]);
        chk($sformatf("i%0d.busy", i),     a[13],    e[13]);
        chk($sformatf("i%0d.done", i),     a[12],    e[12]);
        chk($sformatf("i%0d.pass", i),     a[11],    e[11]);
        chk($sformatf("i%0d.err_cnt", i),  a[10:8],  e[10:8]);
        chk($sformatf("i%0d.fail_vec", i), a[7:4],   e[7:4]);
        chk($sformatf("i%0d.obs_vec", i),  a[3:0],   e[3:0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int i);
    @(negedge clk); st[i] = 1'b1;
    @(negedge clk); st[i] = 1'b0;
  endtask

  // Called at the negedge of the first vector cycle; returns at the done cycle.
  task automatic wait_done(input int i, output int lat, output int busy_n);
    bit ok;
    lat = 1; busy_n = 0; ok = 0;
    repeat (100) begin
      if (dout[i][13]) busy_n++;
      if (dout[i][12]) begin ok = 1; break; end
      @(negedge clk); lat++;
    end
    chk($sformatf("i%0d.done_seen", i), 32'(ok), 32'd1);
  endtask

  task automatic sweep(input int i, output int lat, output int busy_n);
    pulse_start(i);
    wait_done(i, lat, busy_n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int bn;
    int dn;
    rst_n = 1'b0;
    st[0] = 0; st[1] = 0; ab[0] = 0; ab[1] = 0;
    tbl[0] = G_AND; tbl[1] = G_XOR;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst.i0", 32'(dout[0]), 32'h0);
    chk("rst.i1", 32'(dout[1]), 32'h0);
    rst_n = 1'b1;

    // Correct AND gate
    sweep(0, lat, bn);
    chk("and.latency", lat, 13);
    chk("and.busy_cycles", bn, 12);
    chk("and.obs", dout[0][3:0], 4'b1000);
    chk("and.fail", dout[0][7:4], 4'b0000);
    chk("and.err", dout[0][10:8], 3'd0);
    chk("and.pass", dout[0][11], 1'b1);

    // OR in place of AND
    tbl[0] = G_OR;
    sweep(0, lat, bn);
    chk("or.obs", dout[0][3:0], 4'b1110);
    chk("or.fail", dout[0][7:4], 4'b0110);
    chk("or.err", dout[0][10:8], 3'd2);
    chk("or.pass", dout[0][11], 1'b0);

    // NAND
    tbl[0] = G_NAND;
    sweep(0, lat, bn);
    chk("nand.fail", dout[0][7:4], 4'b1111);
    chk("nand.err", dout[0][10:8], 3'd4);

    // Start during vector 1 ignored, abort during vector 2
    tbl[0] = G_OR;
    pulse_start(0);                 // now in cycle k+1
    repeat (4) @(negedge clk);      // k+5, vector 1
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;   // k+6
    chk("restart.xy", dout[0][15:14], 2'b01);
    repeat (2) @(negedge clk);      // k+8, vector 2
    chk("abort.pre_obs", dout[0][3:0], 4'b0010);
    ab[0] = 1'b1;
    @(negedge clk); ab[0] = 1'b0;   // k+9
    chk("abort.outputs", 32'(dout[0]), 32'h0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout[0][12]) dn++;
    end
    chk("abort.no_done", dn, 0);

    // Reset mid-sweep on both instances
    tbl[0] = G_AND;
    fork
      pulse_start(0);
      pulse_start(1);
    join
    repeat (3) @(negedge clk);      // k+4, vector 1 for SETTLE=2
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midrst.i0", 32'(dout[0]), 32'h0);
    chk("midrst.i1", 32'(dout[1]), 32'h0);
    sweep(0, lat, bn);
    chk("post_rst.latency", lat, 13);
    chk("post_rst.pass", dout[0][11], 1'b1);

    // SETTLE=1, back-to-back starts
    tbl[1] = G_XOR;
    sweep(1, lat, bn);
    chk("s1.latency", lat, 9);
    chk("s1.busy_cycles", bn, 8);
    chk("s1.pass", dout[1][11], 1'b1);
    @(negedge clk);
    tbl[1] = G_AND;
    st[1] = 1'b1;
    chk("s1.hold_pass", dout[1][11], 1'b1);
    chk("s1.hold_obs", dout[1][3:0], 4'b0110);
    @(negedge clk); st[1] = 1'b0;
    chk("s1.b2b_busy", dout[1][13], 1'b1);
    chk("s1.b2b_obs_clr", dout[1][3:0], 4'b0000);
    wait_done(1, lat, bn);
    chk("s1.b2b_latency", lat, 9);
    chk("s1.b2b_fail", dout[1][7:4], 4'b1110);
    chk("s1.b2b_err", dout[1][10:8], 3'd3);

    // Randomized traffic on both instances
    repeat (1500) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i] && ($urandom % 3) == 0) tbl[i] = 4'($urandom);
        st[i] = (($urandom % 6) == 0);
        ab[i] = (($urandom % 50) == 0);
      end
      rst_n = (($urandom % 300) != 0);
    end
    @(negedge clk);
    st[0] = 0; st[1] = 0; ab[0] = 0; ab[1] = 0; rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
